// File: rtl/pipe_ctrl_if.sv
// Fetch-to-pipeline payload handshake.
// Fetch is the master, the pipeline sequencer is the slave.
interface pipe_ctrl_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Generic N-stage shift pipeline with per-stage valid, hold,
// bubble insertion, younger-stage flush and perf counters.
module pipe_ctrl #(
    parameter int STAGES = 5,
    parameter int WIDTH  = 64,
    parameter int SW     = $clog2(STAGES)
) (
    input  logic                    clk,
    input  logic                    reset,
    pipe_ctrl_if.slave              fe,
    input  logic [STAGES-1:0]       hold_req,
    input  logic                    flush,
    input  logic [SW-1:0]           flush_stage,
    output logic [STAGES-1:0]       stage_valid,
    output logic [STAGES*WIDTH-1:0] stage_data,
    output logic                    retire,
    output logic [31:0]             retire_count,
    output logic [15:0]             stall_count
);

    logic [STAGES-1:0] sv;
    logic [STAGES-1:0] hv;
    logic [STAGES-1:0] hold;

    // Squash younger stages on flush, then fold holds down toward stage 0
    always_comb begin
        sv   = '0;
        hv   = '0;
        hold = '0;
        for (int i = 0; i < STAGES; i++) begin
            sv[i] = stage_valid[i] & ~(flush & (SW'(i) < flush_stage));
        end
        hv = hold_req & sv;
        for (int i = 0; i < STAGES; i++) begin
            hold[i] = |(hv & ({STAGES{1'b1}} << i));
        end
    end

    assign fe.in_ready = ~hold[0] & ~flush;
    assign retire      = sv[STAGES-1] & ~hold[STAGES-1];

    // Stage registers: hold in place, bubble, or shift from the younger stage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_valid <= '0;
            stage_data  <= '0;
        end else begin
            if (hold[0]) begin
                stage_valid[0] <= sv[0];
            end else begin
                stage_valid[0]        <= fe.in_valid & fe.in_ready;
                stage_data[0+:WIDTH]  <= fe.in_data;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (hold[i]) begin
                    stage_valid[i] <= sv[i];
                end else if (hold[i-1]) begin
                    stage_valid[i] <= 1'b0;
                end else begin
                    stage_valid[i] <= sv[i-1];
                    stage_data[i*WIDTH+:WIDTH] <=
                        stage_data[(i-1)*WIDTH+:WIDTH];
                end
            end
        end
    end

    // Wrapping retire counter and saturating front-end stall counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retire_count <= '0;
            stall_count  <= '0;
        end else begin
            if (retire) begin
                retire_count <= retire_count + 32'd1;
            end
            if (hold[0] && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a retire-order scoreboard.
// Accepted payloads are queued; each retire pops and compares.
module tb_pipe_ctrl;

    localparam int S = 5;
    localparam int W = 16;

    logic           clk;
    logic           reset;
    logic [S-1:0]   hold_req;
    logic           flush;
    logic [2:0]     flush_stage;
    logic [S-1:0]   stage_valid;
    logic [S*W-1:0] stage_data;
    logic           retire;
    logic [31:0]    retire_count;
    logic [15:0]    stall_count;

    int total;
    int bad;
    logic [W-1:0] exp_q[$];

    pipe_ctrl_if #(.WIDTH(W)) fe ();

    pipe_ctrl #(.STAGES(S), .WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .fe           (fe),
        .hold_req     (hold_req),
        .flush        (flush),
        .flush_stage  (flush_stage),
        .stage_valid  (stage_valid),
        .stage_data   (stage_data),
        .retire       (retire),
        .retire_count (retire_count),
        .stall_count  (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] sd(input int i);
        return stage_data[i*W+:W];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [W-1:0] base);
        for (int i = 0; i < S; i++) begin
            fe.in_valid = 1'b1;
            fe.in_data  = base + W'(i);
            tick();
        end
        fe.in_valid = 1'b0;
    endtask

    // Scoreboard: push on acceptance, pop and compare on retire
    always @(negedge clk) begin
        if (reset && fe.in_valid && fe.in_ready) begin
            exp_q.push_back(fe.in_data);
        end
        if (reset && retire) begin
            if (exp_q.size() == 0) begin
                chk("retire_unexpected", 32'd1, 32'd0);
            end else begin
                chk("retire_data", 32'(sd(S-1)), 32'(exp_q.pop_front()));
            end
        end
        if (reset && flush) begin
            chk("flush_stage_legal", 32'(flush_stage < 3'(S)), 32'd1);
        end
    end

    initial begin
        total       = 0;
        bad         = 0;
        reset       = 1'b0;
        hold_req    = '0;
        flush       = 1'b0;
        flush_stage = '0;
        fe.in_valid = 1'b0;
        fe.in_data  = '0;

        #2;
        chk("rst_valid", 32'(stage_valid), 32'd0);
        chk("rst_data0", 32'(sd(0)), 32'd0);
        chk("rst_ready", 32'(fe.in_ready), 32'd1);
        chk("rst_retire", 32'(retire), 32'd0);
        chk("rst_rcnt", retire_count, 32'd0);
        chk("rst_scnt", 32'(stall_count), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // 1: stream 0x1000..0x1004, no holds
        fill(16'h1000);
        chk("s1_valid", 32'(stage_valid), 32'h1F);
        chk("s1_stage4", 32'(sd(4)), 32'h1000);
        chk("s1_stage0", 32'(sd(0)), 32'h1004);
        for (int i = 0; i < S; i++) begin
            @(negedge clk);
            chk("s1_retire", 32'(retire), 32'd1);
            tick();
        end
        chk("s1_rcnt", retire_count, 32'd5);
        chk("s1_empty", 32'(stage_valid), 32'd0);
        chk("s1_sb", 32'(exp_q.size()), 32'd0);

        // 2: hold stage 3 for three cycles on a full pipe
        fill(16'hA000);
        hold_req = 5'b01000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("s2_ready", 32'(fe.in_ready), 32'd0);
            chk("s2_retire", 32'(retire), 32'(i == 0));
            tick();
            chk("s2_bubble", 32'(stage_valid), 32'h0F);
        end
        chk("s2_d0", 32'(sd(0)), 32'hA004);
        chk("s2_d1", 32'(sd(1)), 32'hA003);
        chk("s2_d2", 32'(sd(2)), 32'hA002);
        chk("s2_d3", 32'(sd(3)), 32'hA001);
        chk("s2_scnt", 32'(stall_count), 32'd3);
        chk("s2_rcnt", retire_count, 32'd6);
        hold_req = '0;
        repeat (6) tick();
        chk("s2_rcnt_drain", retire_count, 32'd10);
        chk("s2_sb", 32'(exp_q.size()), 32'd0);

        // 3: flush at stage 2 with an offered payload
        fill(16'hB000);
        flush       = 1'b1;
        flush_stage = 3'd2;
        fe.in_valid = 1'b1;
        fe.in_data  = 16'hBF00;
        @(negedge clk);
        chk("s3_ready", 32'(fe.in_ready), 32'd0);
        chk("s3_retire", 32'(retire), 32'd1);
        tick();
        flush       = 1'b0;
        fe.in_valid = 1'b0;
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        chk("s3_valid", 32'(stage_valid), 32'h18);
        chk("s3_d4", 32'(sd(4)), 32'hB001);
        chk("s3_d3", 32'(sd(3)), 32'hB002);
        chk("s3_rcnt", retire_count, 32'd11);
        repeat (3) tick();
        chk("s3_rcnt_drain", retire_count, 32'd13);

        // 4: flush at stage 2 with a hold from a squashed stage
        fill(16'hC000);
        flush       = 1'b1;
        flush_stage = 3'd2;
        hold_req    = 5'b00010;
        @(negedge clk);
        chk("s4_ready", 32'(fe.in_ready), 32'd0);
        chk("s4_retire", 32'(retire), 32'd1);
        tick();
        flush    = 1'b0;
        hold_req = '0;
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        chk("s4_valid", 32'(stage_valid), 32'h18);
        chk("s4_d4", 32'(sd(4)), 32'hC001);
        chk("s4_d3", 32'(sd(3)), 32'hC002);
        chk("s4_scnt", 32'(stall_count), 32'd3);
        repeat (3) tick();
        chk("s4_rcnt", retire_count, 32'd16);
        chk("s4_sb", 32'(exp_q.size()), 32'd0);

        // 5: hold request on an empty stage is ignored
        fe.in_valid = 1'b1;
        fe.in_data  = 16'hD00D;
        tick();
        fe.in_valid = 1'b0;
        chk("s5_valid0", 32'(stage_valid), 32'h01);
        hold_req = 5'b10000;
        @(negedge clk);
        chk("s5_ready", 32'(fe.in_ready), 32'd1);
        tick();
        chk("s5_valid1", 32'(stage_valid), 32'h02);
        chk("s5_d1", 32'(sd(1)), 32'hD00D);
        chk("s5_scnt", 32'(stall_count), 32'd3);
        hold_req = '0;
        repeat (5) tick();
        chk("s5_rcnt", retire_count, 32'd17);

        // 6: long hold on stage 4 saturates, then async reset
        fe.in_valid = 1'b1;
        fe.in_data  = 16'hE00E;
        tick();
        fe.in_valid = 1'b0;
        repeat (4) tick();
        chk("s6_at4", 32'(stage_valid), 32'h10);
        hold_req = 5'b10000;
        repeat (65540) tick();
        chk("s6_scnt_sat", 32'(stall_count), 32'hFFFF);
        chk("s6_valid", 32'(stage_valid), 32'h10);
        chk("s6_d4", 32'(sd(4)), 32'hE00E);
        chk("s6_retire", 32'(retire), 32'd0);
        chk("s6_sb", 32'(exp_q.size()), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("s6_rst_valid", 32'(stage_valid), 32'd0);
        chk("s6_rst_d4", 32'(sd(4)), 32'd0);
        chk("s6_rst_rcnt", retire_count, 32'd0);
        chk("s6_rst_scnt", 32'(stall_count), 32'd0);
        chk("s6_rst_ready", 32'(fe.in_ready), 32'd1);
        chk("s6_rst_retire", 32'(retire), 32'd0);
        exp_q.delete();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
